// File: rtl/unit_fb_trigger.sv
// unit_fb_trigger: closed-loop feedback trigger.
// Fires a fixed-width pulse when a spike from the host-selected unit arrives,
// then holds off further triggers for a refractory window. Hits and dropped
// (lockout) target spikes are counted with saturating counters.
module unit_fb_trigger #(
  parameter int ID_W       = 16,
  parameter int PULSE_CYC  = 25000,
  parameter int REFRAC_CYC = 250000,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ID_W-1:0]  target_unit_id,
  input  logic             fb_en,
  input  logic             spk_valid,
  input  logic [ID_W-1:0]  spk_unit_id,
  input  logic             clr_cnt,
  output logic             fb_pulse,
  output logic             fb_busy,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  // One down-counter serves both the pulse and the refractory phase, so it is
  // sized for the longer of the two.
  localparam int MAX_CYC = (PULSE_CYC > REFRAC_CYC) ? PULSE_CYC : REFRAC_CYC;
  localparam int TIMER_W = (MAX_CYC > 0) ? $clog2(MAX_CYC + 1) : 1;

  localparam logic [TIMER_W-1:0] PULSE_LOAD  = TIMER_W'(PULSE_CYC - 1);
  // REFRAC_CYC == 0 skips the refractory state entirely; the load value is
  // then never used but must still be a legal non-negative constant.
  localparam logic [TIMER_W-1:0] REFRAC_LOAD = TIMER_W'((REFRAC_CYC > 0) ? REFRAC_CYC - 1 : 0);
  localparam bit                 HAS_REFRAC  = (REFRAC_CYC > 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PULSE  = 2'd1,
    ST_REFRAC = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               pulse_q, pulse_d;
  logic               busy_q,  busy_d;
  logic [CNT_W-1:0]   hit_cnt_q,  hit_cnt_d;
  logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;

  logic match;
  logic hit_inc;
  logic miss_inc;

  // An all-ones target is the host's "disabled" code and never matches.
  assign match = spk_valid & fb_en
               & (spk_unit_id == target_unit_id)
               & (target_unit_id != {ID_W{1'b1}});

  // Next-state and timer: a match only starts a pulse from IDLE; dropping
  // fb_en while busy aborts straight back to IDLE.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    hit_inc  = 1'b0;
    miss_inc = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (match) begin
          state_d = ST_PULSE;
          timer_d = PULSE_LOAD;
          hit_inc = 1'b1;
        end
      end
      ST_PULSE: begin
        miss_inc = match;
        if (!fb_en) begin
          state_d = ST_IDLE;
          timer_d = '0;
        end else if (timer_q == '0) begin
          if (HAS_REFRAC) begin
            state_d = ST_REFRAC;
            timer_d = REFRAC_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      ST_REFRAC: begin
        miss_inc = match;
        if (!fb_en) begin
          state_d = ST_IDLE;
          timer_d = '0;
        end else if (timer_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered, so the pins come
  // straight off flops and cannot glitch.
  always_comb begin
    pulse_d = (state_d == ST_PULSE);
    busy_d  = (state_d == ST_PULSE) || (state_d == ST_REFRAC);
  end

  // Saturating counters; a clear wins over an increment in the same cycle.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (clr_cnt) begin
      hit_cnt_d  = '0;
      miss_cnt_d = '0;
    end else begin
      if (hit_inc && (hit_cnt_q != {CNT_W{1'b1}})) begin
        hit_cnt_d = hit_cnt_q + CNT_W'(1);
      end
      if (miss_inc && (miss_cnt_q != {CNT_W{1'b1}})) begin
        miss_cnt_d = miss_cnt_q + CNT_W'(1);
      end
    end
  end

  // State, timer, output and counter registers; reset asserts asynchronously
  // so the feedback output drops without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      pulse_q    <= 1'b0;
      busy_q     <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      pulse_q    <= pulse_d;
      busy_q     <= busy_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign fb_pulse = pulse_q;
  assign fb_busy  = busy_q;
  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;

endmodule
